// File: rtl/clk_gen_multi_if.sv
// Register-write and per-channel control/output bundle for clk_gen_multi.
// master drives the controls (host side); slave is the generator itself.
interface clk_gen_multi_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 32,
  parameter int CHAN_W   = 2
);
  logic [CHANNELS-1:0] enable;
  logic                sync;
  logic                wr_en;
  logic [CHAN_W-1:0]   wr_chan;
  logic                wr_phase;
  logic [DIV_W-1:0]    wr_data;
  logic [CHANNELS-1:0] clk_out;
  logic [CHANNELS-1:0] overflow;

  modport master (
    output enable, sync, wr_en, wr_chan, wr_phase, wr_data,
    input  clk_out, overflow
  );

  modport slave (
    input  enable, sync, wr_en, wr_chan, wr_phase, wr_data,
    output clk_out, overflow
  );
endinterface

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable divider: each channel toggles clk_out every D cycles (f_clk/(2*D)).
// Optional per-channel phase offset is compiled in when CLK_GEN_PHASE_EN is defined.
module clk_gen_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 32,
  parameter int CHAN_W      = 2,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  clk_gen_multi_if.slave   bus
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] cnt, cnt_nx;
    logic [DIV_W-1:0] act_d, act_nx;
    logic [DIV_W-1:0] shd_d, shd_nx;
    logic [DIV_W-1:0] start;
    logic             clk_q, clk_nx;
    logic             ovf_q, ovf_nx;
    logic             wr_hit;

    // Out-of-range channel numbers match no generate index, so they are dropped.
    assign wr_hit = bus.wr_en && (bus.wr_chan == CHAN_W'(i));

    // shd_nx is also what any load takes, so a write lands in active_D the same cycle.
    always_comb begin
      shd_nx = shd_d;
      if (wr_hit && !bus.wr_phase) shd_nx = bus.wr_data;
    end

`ifdef CLK_GEN_PHASE_EN
    logic [DIV_W-1:0] p_q, p_nx;

    always_comb begin
      p_nx = p_q;
      if (wr_hit && bus.wr_phase) p_nx = bus.wr_data;
    end

    // Start is clamped against the D being loaded, so cnt never exceeds D-1.
    always_comb begin
      start = '0;
      if (shd_nx != '0) begin
        if (p_nx < shd_nx) start = p_nx;
        else               start = shd_nx - DIV_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) p_q <= '0;
      else       p_q <= p_nx;
    end
`else
    assign start = '0;
`endif

    always_comb begin
      cnt_nx = cnt + DIV_W'(1);
      act_nx = act_d;
      clk_nx = clk_q;
      ovf_nx = 1'b0;
      if (bus.sync || !bus.enable[i]) begin
        cnt_nx = start;
        clk_nx = 1'b0;
        act_nx = shd_nx;
      end else if (act_d == '0) begin
        cnt_nx = '0;
        clk_nx = 1'b0;
        act_nx = shd_nx;
      end else if (cnt >= act_d - DIV_W'(1)) begin
        // >= rather than == so an overshooting count can never run to wrap.
        cnt_nx = '0;
        clk_nx = !clk_q;
        ovf_nx = 1'b1;
        act_nx = shd_nx;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        act_d <= DIV_W'(DEFAULT_DIV);
        shd_d <= DIV_W'(DEFAULT_DIV);
        clk_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        cnt   <= cnt_nx;
        act_d <= act_nx;
        shd_d <= shd_nx;
        clk_q <= clk_nx;
        ovf_q <= ovf_nx;
      end
    end

    assign bus.clk_out[i]  = clk_q;
    assign bus.overflow[i] = ovf_q;
  end

endmodule
